// File: rtl/serial_add_ctrl_if.sv
// Handshake bus for the bit-serial adder: operand request channel and result channel.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output A, B, Cin, in_valid, out_ready,
    input  in_ready, S, Cout, Ovf, out_valid
  );

  modport slave (
    input  A, B, Cin, in_valid, out_ready,
    output in_ready, S, Cout, Ovf, out_valid
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice reused for WIDTH cycles, LSB first,
// with a valid/ready handshake on both the operand and result sides.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_s;
  logic             r_c, r_cmsb;
  logic [CW-1:0]    r_cnt;
  logic             w_sum, w_co, w_last, w_load;
  logic             w_in_ready, w_out_valid;

  full_adder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_c),
    .o_s (w_sum),
    .o_c (w_co)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_load = bus.in_valid && (r_state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = SHIFT;
      end
      SHIFT: if (w_last) w_next = DONE;
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_s    <= '0;
      r_c    <= 1'b0;
      r_cmsb <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_a    <= bus.A;
      r_b    <= bus.B;
      r_s    <= '0;
      r_c    <= bus.Cin;
      r_cmsb <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_s   <= {w_sum, r_s[WIDTH-1:1]};
      r_c   <= w_co;
      r_cnt <= r_cnt + 1'b1;
      // Carry entering the MSB slice, kept for signed overflow.
      if (w_last) r_cmsb <= r_c;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.S         = r_s;
  assign bus.Cout      = r_c;
  assign bus.Ovf       = r_cmsb ^ r_c;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed vector table, reset/stall corner cases,
// and a randomized run against an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nmis = 0;
  int n_in = 0;
  int n_out = 0;
  int ops_done = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready)   n_in  <= n_in + 1;
      if (bus.out_valid && bus.out_ready) n_out <= n_out + 1;
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition; overflow when like-signed operands give an unlike-signed sum.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output logic [W-1:0] s, output logic cout, output logic ovf);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    s    = full[W-1:0];
    cout = full[W];
    ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  // Entered #1 after an edge with the block idle; returns likewise.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input int stall, input bit inject, input string tag);
    int cyc;
    chk({tag, " in_ready idle"}, {31'd0, bus.in_ready}, 32'd1);
    bus.A = a; bus.B = b; bus.Cin = cin; bus.in_valid = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 4 * W) begin
      if (inject) bus.in_valid = 1'b1;
      bus.A = W'($urandom); bus.B = W'($urandom); bus.Cin = 1'($urandom);
      chk({tag, " in_ready busy"}, {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({tag, " latency"}, cyc, W);
    for (int i = 0; i <= stall; i++) begin
      chk({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, " in_ready done"}, {31'd0, bus.in_ready}, 32'd0);
      chk({tag, " S"}, {24'd0, bus.S}, {24'd0, es});
      chk({tag, " Cout"}, {31'd0, bus.Cout}, {31'd0, ec});
      chk({tag, " Ovf"}, {31'd0, bus.Ovf}, {31'd0, eo});
      if (i == stall) bus.out_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk({tag, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, " in_ready back"}, {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b0;
    ops_done++;
  endtask

  initial begin
    logic [W-1:0] ra, rb, rs;
    logic         rc, rco, rov;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
    tbl[3] = '{8'h35, 8'h4A, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};

    bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

    #1;
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset S", {24'd0, bus.S}, 32'd0);
    chk("reset Cout", {31'd0, bus.Cout}, 32'd0);
    chk("reset Ovf", {31'd0, bus.Ovf}, 32'd0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset holds idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].cout, tbl[i].ovf,
             (i == 3) ? 5 : 0, (i == 1), $sformatf("vec%0d", i));

    // Asynchronous reset mid-operation, in the 4th compute cycle.
    bus.A = 8'hAA; bus.B = 8'h55; bus.Cin = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort S", {24'd0, bus.S}, 32'd0);
    chk("abort Cout", {31'd0, bus.Cout}, 32'd0);
    chk("abort Ovf", {31'd0, bus.Ovf}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("abort no out_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    rst = 1'b0;
    bus.out_ready = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0, 1'b0, "post-reset");

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      model(ra, rb, rc, rs, rco, rov);
      run_op(ra, rb, rc, rs, rco, rov,
             ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
             1'($urandom), $sformatf("rnd%0d", n));
    end

    @(posedge clk); #1;
    chk("results count", n_out, ops_done);
    chk("accepts count", n_in, ops_done + 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
